// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP.
// Open-drain SDA/SCL; each bit slot is four quarter phases of CLK_DIV clk.
module i2c_master_controller #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] addr,
   input  logic [7:0] data_in,
   input  logic       enable,
   input  logic       rw,
   output logic [7:0] data_out,
   output logic       ready,
   inout  wire        i2c_sda,
   inout  wire        i2c_scl,
   output logic [3:0] dbg_state
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_START      = 4'd1;
   localparam logic [3:0] S_ADDR       = 4'd2;
   localparam logic [3:0] S_ADDR_ACK   = 4'd3;
   localparam logic [3:0] S_WRITE_DATA = 4'd4;
   localparam logic [3:0] S_WRITE_ACK  = 4'd5;
   localparam logic [3:0] S_READ_DATA  = 4'd6;
   localparam logic [3:0] S_READ_ACK   = 4'd7;
   localparam logic [3:0] S_STOP       = 4'd8;

   logic [3:0]       state, nxt_state;
   logic [DIV_W-1:0] div_cnt, nxt_div;
   logic [1:0]       phase, nxt_phase;
   logic [2:0]       bit_cnt, nxt_bit;
   logic [7:0]       shreg, nxt_sh;
   logic [7:0]       rx, nxt_rx;
   logic [7:0]       data_q, nxt_data_q;
   logic             rw_q, nxt_rw;
   logic             nack_q, nxt_nack;
   logic             bus_free, nxt_free;
   logic [7:0]       nxt_out;
   logic             sda_low, scl_low, nxt_sda_low, nxt_scl_low;
   logic             tick, slot_end, sample, sda_in;

   assign sda_in   = i2c_sda;
   assign tick     = (div_cnt == DIV_LAST);
   assign slot_end = tick && (phase == 2'd3);
   // Slave data is taken on the edge that enters phase 2 (SCL about to rise).
   assign sample   = tick && (phase == 2'd1);

   // Handshake: ready=1 whenever the FSM is in IDLE. A request (enable=1) is taken
   // on a clock edge in IDLE once one bit slot of bus-free time has passed since the
   // last STOP; ready drops on that same edge. Hold enable until ready falls.
   always_comb begin
      nxt_state  = state;
      nxt_div    = div_cnt;
      nxt_phase  = phase;
      nxt_bit    = bit_cnt;
      nxt_sh     = shreg;
      nxt_rx     = rx;
      nxt_data_q = data_q;
      nxt_rw     = rw_q;
      nxt_nack   = nack_q;
      nxt_free   = bus_free;
      nxt_out    = data_out;

      if (state != S_IDLE || !bus_free) begin
         nxt_div = tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) nxt_phase = phase + 2'd1;
      end

      case (state)
         S_IDLE: begin
            if (slot_end) nxt_free = 1'b1;
            if (enable && (bus_free || slot_end)) begin
               nxt_state  = S_START;
               nxt_div    = '0;
               nxt_phase  = 2'd0;
               nxt_bit    = 3'd0;
               nxt_sh     = {addr, rw};
               nxt_rw     = rw;
               nxt_data_q = data_in;
               nxt_free   = 1'b0;
            end
         end
         S_START: if (slot_end) nxt_state = S_ADDR;
         S_ADDR, S_WRITE_DATA: begin
            if (slot_end) begin
               nxt_sh  = {shreg[6:0], 1'b0};
               nxt_bit = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  nxt_state = (state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
            end
         end
         S_ADDR_ACK: begin
            if (sample) nxt_nack = sda_in;
            if (slot_end) begin
               if (nack_q) begin
                  nxt_state = S_STOP;
               end else if (rw_q) begin
                  nxt_state = S_READ_DATA;
               end else begin
                  nxt_state = S_WRITE_DATA;
                  nxt_sh    = data_q;
               end
            end
         end
         S_WRITE_ACK: if (slot_end) nxt_state = S_STOP;
         S_READ_DATA: begin
            if (sample) nxt_rx = {rx[6:0], sda_in};
            if (slot_end) begin
               nxt_bit = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) nxt_state = S_READ_ACK;
            end
         end
         S_READ_ACK: begin
            if (slot_end) begin
               nxt_out   = rx;
               nxt_state = S_STOP;
            end
         end
         S_STOP: if (slot_end) nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   // Line drives are decoded from the next state so the pins come straight off flops.
   always_comb begin
      nxt_sda_low = 1'b0;
      nxt_scl_low = 1'b0;
      case (nxt_state)
         S_START: begin
            nxt_sda_low = nxt_phase[1];
            nxt_scl_low = (nxt_phase == 2'd3);
         end
         S_STOP: begin
            nxt_sda_low = (nxt_phase != 2'd3);
            nxt_scl_low = !nxt_phase[1];
         end
         S_ADDR, S_WRITE_DATA: begin
            nxt_sda_low = !nxt_sh[7];
            nxt_scl_low = !nxt_phase[1];
         end
         S_ADDR_ACK, S_WRITE_ACK, S_READ_DATA, S_READ_ACK: nxt_scl_low = !nxt_phase[1];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         phase    <= 2'd0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'h00;
         rx       <= 8'h00;
         data_q   <= 8'h00;
         rw_q     <= 1'b0;
         nack_q   <= 1'b0;
         bus_free <= 1'b1;
         data_out <= 8'h00;
         ready    <= 1'b0;
         sda_low  <= 1'b0;
         scl_low  <= 1'b0;
      end else begin
         state    <= nxt_state;
         div_cnt  <= nxt_div;
         phase    <= nxt_phase;
         bit_cnt  <= nxt_bit;
         shreg    <= nxt_sh;
         rx       <= nxt_rx;
         data_q   <= nxt_data_q;
         rw_q     <= nxt_rw;
         nack_q   <= nxt_nack;
         bus_free <= nxt_free;
         data_out <= nxt_out;
         ready    <= (nxt_state == S_IDLE);
         sda_low  <= nxt_sda_low;
         scl_low  <= nxt_scl_low;
      end
   end

   assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
   assign i2c_scl   = scl_low ? 1'b0 : 1'bz;
   assign dbg_state = state;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: pulled-up bus, responder slave at 7'h2A,
// bus monitor/scoreboard, table of directed transactions plus reset/back-to-back sequences.
module tb_i2c_master_controller;

   logic       clk;
   logic       rst;
   logic [6:0] addr;
   logic [7:0] data_in;
   logic       enable;
   logic       rw;
   logic [7:0] data_out;
   logic       ready;
   logic [3:0] dbg_state;
   wire        i2c_sda;
   wire        i2c_scl;

   int checks = 0;
   int errors = 0;

   i2c_master_controller #(.CLK_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data_in   (data_in),
      .enable    (enable),
      .rw        (rw),
      .data_out  (data_out),
      .ready     (ready),
      .i2c_sda   (i2c_sda),
      .i2c_scl   (i2c_scl),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bus, slave and monitor ----------------
   logic s_low = 1'b0;
   pullup (i2c_sda);
   pullup (i2c_scl);
   assign i2c_sda = s_low ? 1'b0 : 1'bz;

   logic [7:0] slave_mem = 8'hCD;
   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];
   int         gap_q[$];
   logic       prev_sda = 1'b1, prev_scl = 1'b1;
   logic       sda_n, scl_n;
   logic       in_xfer = 1'b0, addressed = 1'b0, rd = 1'b0;
   logic [7:0] sh = 8'h00;
   int         bitn = 0, byte_idx = 0;
   int         start_cnt = 0, stop_cnt = 0, sda_viol = 0;
   int         cyc = 0, last_stop = 0;

   always @(negedge clk) begin
      sda_n = i2c_sda;
      scl_n = i2c_scl;
      cyc++;
      if (!rst) begin
         in_xfer  = 1'b0;
         bitn     = 0;
         byte_idx = 0;
         s_low    = 1'b0;
      end else if (prev_scl && scl_n && (prev_sda != sda_n)) begin
         if (!sda_n) begin
            if (in_xfer) sda_viol++;
            in_xfer  = 1'b1;
            bitn     = 0;
            byte_idx = 0;
            start_cnt++;
            gap_q.push_back(cyc - last_stop);
         end else begin
            if (!in_xfer || bitn != 1) sda_viol++;
            in_xfer   = 1'b0;
            stop_cnt++;
            last_stop = cyc;
            s_low     = 1'b0;
         end
      end else if (!prev_scl && scl_n && in_xfer) begin
         if (bitn < 8) begin
            sh = {sh[6:0], sda_n};
            bitn++;
         end else begin
            obs_q.push_back({sh, sda_n});
            bitn = 0;
            byte_idx++;
         end
      end else if (prev_scl && !scl_n && in_xfer) begin
         s_low = 1'b0;
         if (bitn == 8 && byte_idx == 0) begin
            addressed = (sh[7:1] == 7'h2A);
            rd        = sh[0];
            s_low     = addressed;
         end else if (bitn == 8 && byte_idx == 1 && addressed && !rd) begin
            slave_mem = sh;
            s_low     = 1'b1;
         end else if (byte_idx == 1 && addressed && rd && bitn < 8) begin
            s_low = !slave_mem[7 - bitn];
         end
      end
      prev_sda = sda_n;
      prev_scl = scl_n;
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_bus(input string tag);
      logic [8:0] e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_bus: got no byte expected %h", tag, e);
         end else begin
            o = obs_q.pop_front();
            check({tag, "_bus"}, int'(o), int'(e));
         end
      end
      check({tag, "_bus_extra"}, obs_q.size(), 0);
      obs_q.delete();
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_pre_ready"}, int'(ready), 1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      logic       rw;
      logic [8:0] exp_b0;
      logic [8:0] exp_b1;
      logic       has_b1;
      logic [7:0] exp_out;
      logic [7:0] exp_mem;
      int         exp_clk;
   } vec_t;

   vec_t tbl[6];

   task automatic apply_vec(input vec_t v, input string tag);
      int n;
      wait_ready(tag);
      repeat (10) @(negedge clk);
      exp_q.push_back(v.exp_b0);
      if (v.has_b1) exp_q.push_back(v.exp_b1);
      addr    = v.addr;
      data_in = v.data;
      rw      = v.rw;
      enable  = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      addr    = 7'h7F;
      data_in = ~v.data;
      rw      = ~v.rw;
      check({tag, "_accept"}, int'(ready), 0);
      n = 1;
      while (!ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n - 1, v.exp_clk);
      check({tag, "_data_out"}, int'(data_out), int'(v.exp_out));
      check({tag, "_slave_mem"}, int'(slave_mem), int'(v.exp_mem));
      compare_bus(tag);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0, p0;
      vec_t v;

      tbl[0] = '{7'h2A, 8'hAA, 1'b0, {8'h54, 1'b0}, {8'hAA, 1'b0}, 1'b1, 8'h00, 8'hAA, 160};
      tbl[1] = '{7'h2A, 8'h00, 1'b1, {8'h55, 1'b0}, {8'hAA, 1'b1}, 1'b1, 8'hAA, 8'hAA, 160};
      tbl[2] = '{7'h11, 8'h77, 1'b0, {8'h22, 1'b1}, 9'h000,        1'b0, 8'hAA, 8'hAA, 88};
      tbl[3] = '{7'h2A, 8'h5A, 1'b0, {8'h54, 1'b0}, {8'h5A, 1'b0}, 1'b1, 8'hAA, 8'h5A, 160};
      tbl[4] = '{7'h2A, 8'hFF, 1'b1, {8'h55, 1'b0}, {8'h5A, 1'b1}, 1'b1, 8'h5A, 8'h5A, 160};
      tbl[5] = '{7'h11, 8'h00, 1'b1, {8'h23, 1'b1}, 9'h000,        1'b0, 8'h5A, 8'h5A, 88};

      rst     = 1'b0;
      addr    = 7'h00;
      data_in = 8'h00;
      enable  = 1'b0;
      rw      = 1'b0;

      // Reset state and release
      repeat (10) @(negedge clk);
      check("rst_ready", int'(ready), 0);
      check("rst_data_out", int'(data_out), 0);
      check("rst_sda", int'(i2c_sda), 1);
      check("rst_scl", int'(i2c_scl), 1);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", int'(ready), 1);

      // Table: write, read, NACK, second write/read, NACKed read
      for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // enable held high: back-to-back writes separated by an idle slot
      wait_ready("b2b");
      repeat (10) @(negedge clk);
      gap_q.delete();
      s0 = start_cnt;
      p0 = stop_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({8'h54, 1'b0});
         exp_q.push_back({8'hAA, 1'b0});
      end
      addr    = 7'h2A;
      data_in = 8'hAA;
      rw      = 1'b0;
      enable  = 1'b1;
      repeat (500) @(negedge clk);
      enable  = 1'b0;
      repeat (200) @(negedge clk);
      check("b2b_ready", int'(ready), 1);
      check("b2b_starts", start_cnt - s0, 3);
      check("b2b_stops", stop_cnt - p0, 3);
      check("b2b_gap_count", gap_q.size(), 3);
      if (gap_q.size() == 3) begin
         check("b2b_gap1", gap_q[1], 14);
         check("b2b_gap2", gap_q[2], 14);
      end
      check("b2b_slave_mem", int'(slave_mem), 8'hAA);
      compare_bus("b2b");

      // Reset in the middle of the data byte of a write
      repeat (10) @(negedge clk);
      exp_q.push_back({8'h54, 1'b0});
      addr    = 7'h2A;
      data_in = 8'h96;
      rw      = 1'b0;
      enable  = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      repeat (104) @(negedge clk);
      check("mid_state", int'(dbg_state), 4);
      check("mid_scl_low", int'(i2c_scl), 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_scl", int'(i2c_scl), 1);
      check("mid_rst_sda", int'(i2c_sda), 1);
      check("mid_rst_ready", int'(ready), 0);
      check("mid_rst_data_out", int'(data_out), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_ready_after_rst", int'(ready), 1);
      check("mid_slave_mem", int'(slave_mem), 8'hAA);
      compare_bus("mid");

      v = '{7'h2A, 8'h3C, 1'b0, {8'h54, 1'b0}, {8'h3C, 1'b0}, 1'b1, 8'h00, 8'h3C, 160};
      apply_vec(v, "post_wr");
      v = '{7'h2A, 8'h00, 1'b1, {8'h55, 1'b0}, {8'h3C, 1'b1}, 1'b1, 8'h3C, 8'h3C, 160};
      apply_vec(v, "post_rd");

      check("sda_stable_viol", sda_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
